// File: rtl/counter_pkg.sv
// Shared direction and mode definitions for counter blocks.
package counter_pkg;

    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_dir_e;

    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;

endpackage : counter_pkg

// File: rtl/counter_flags.sv
// Sticky overflow/underflow flags; a set in the same cycle as a clear wins.
module counter_flags (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic set_ovf,
    input  logic set_unf,
    output logic ovf,
    output logic unf
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (set_ovf) begin
                ovf <= 1'b1;
            end else if (clr) begin
                ovf <= 1'b0;
            end

            if (set_unf) begin
                unf <= 1'b1;
            end else if (clr) begin
                unf <= 1'b0;
            end
        end
    end

endmodule : counter_flags

// File: rtl/updown_counter_mod.sv
// Up/down counter over 0..MAX_VAL with wrap or saturate at the limits,
// clamped synchronous load, terminal-count pulse and sticky ovf/unf flags.
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = (1 << WIDTH) - 1,
    parameter bit SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    if (WIDTH < 2 || MAX_VAL == 0 ||
        longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_params
        $fatal(1, "updown_counter_mod: illegal WIDTH/MAX_VAL combination");
    end

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    cnt_dir_e         dir;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_next;
    logic             tc_next;
    logic             set_ovf;
    logic             set_unf;

    assign dir          = cnt_dir_e'(up_down);
    assign at_max       = (count == MAX_V);
    assign at_min       = (count == '0);
    // Clamping on load keeps count within 0..MAX_VAL at all times.
    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

    always_comb begin
        count_next = count;
        tc_next    = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        if (load) begin
            count_next = load_clamped;
        end else if (en) begin
            if (dir == CNT_UP) begin
                if (at_max) begin
                    count_next = (SATURATE == MODE_SAT) ? MAX_V : '0;
                    tc_next    = 1'b1;
                    set_ovf    = 1'b1;
                end else begin
                    count_next = count + 1'b1;
                end
            end else begin
                if (at_min) begin
                    count_next = (SATURATE == MODE_SAT) ? '0 : MAX_V;
                    tc_next    = 1'b1;
                    set_unf    = 1'b1;
                end else begin
                    count_next = count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            tc    <= 1'b0;
        end else begin
            count <= count_next;
            tc    <= tc_next;
        end
    end

    counter_flags u_flags (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr_flags),
        .set_ovf (set_ovf),
        .set_unf (set_unf),
        .ovf     (ovf),
        .unf     (unf)
    );

endmodule : updown_counter_mod

// File: tb/tb_updown_counter_mod.sv
// Wrap and saturate instances driven in lockstep, checked cycle by cycle
// against an arithmetic reference model through expected-value queues.
module tb_updown_counter_mod;

    localparam int W   = 4;
    localparam int MV  = 9;
    localparam int VW  = W + 5;

    logic         clk;
    logic         reset;
    logic         en;
    logic         up_down;
    logic         load;
    logic [W-1:0] load_val;
    logic         clr_flags;

    logic [W-1:0] count_w, count_s;
    logic         at_max_w, at_min_w, tc_w, ovf_w, unf_w;
    logic         at_max_s, at_min_s, tc_s, ovf_s, unf_s;

    logic [VW-1:0] exp_q0[$];
    logic [VW-1:0] exp_q1[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int m_cnt[2];
    bit m_ovf[2];
    bit m_unf[2];

    updown_counter_mod #(.WIDTH(W), .MAX_VAL(MV), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .clr_flags(clr_flags), .count(count_w),
        .at_max(at_max_w), .at_min(at_min_w), .tc(tc_w), .ovf(ovf_w), .unf(unf_w)
    );

    updown_counter_mod #(.WIDTH(W), .MAX_VAL(MV), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .clr_flags(clr_flags), .count(count_s),
        .at_max(at_max_s), .at_min(at_min_s), .tc(tc_s), .ovf(ovf_s), .unf(unf_s)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        reset     = 1'b0;
        en        = 1'b0;
        up_down   = 1'b1;
        load      = 1'b0;
        load_val  = '0;
        clr_flags = 1'b0;
    end

    // reference model: next state from the behavioural rules, plain integers
    task automatic model_step(input int sat, input bit rst, input bit e, input bit ud,
                              input bit ld, input int lv, input bit clr,
                              output logic [VW-1:0] vec);
        int c;
        bit t;
        bit lim_up;
        bit lim_dn;
        c = m_cnt[sat];
        t = 1'b0;
        if (!rst) begin
            c = 0;
            m_ovf[sat] = 1'b0;
            m_unf[sat] = 1'b0;
        end else if (ld) begin
            c = (lv > MV) ? MV : lv;
            if (clr) begin
                m_ovf[sat] = 1'b0;
                m_unf[sat] = 1'b0;
            end
        end else begin
            lim_up = e && ud && (c == MV);
            lim_dn = e && !ud && (c == 0);
            if (e) begin
                if (ud) c = (sat == 1) ? ((c + 1 > MV) ? MV : c + 1) : (c + 1) % (MV + 1);
                else    c = (sat == 1) ? ((c - 1 < 0) ? 0 : c - 1) : (c + MV) % (MV + 1);
            end
            t = lim_up || lim_dn;
            if (clr) begin
                m_ovf[sat] = 1'b0;
                m_unf[sat] = 1'b0;
            end
            if (lim_up) m_ovf[sat] = 1'b1;
            if (lim_dn) m_unf[sat] = 1'b1;
        end
        m_cnt[sat] = c;
        vec = {W'(c), t, m_ovf[sat], m_unf[sat], c == MV, c == 0};
    endtask

    // driver: one clock of stimulus, expected result queued for each instance
    task automatic drive(input bit rst, input bit e, input bit ud, input bit ld,
                         input int lv, input bit clr);
        logic [VW-1:0] v0;
        logic [VW-1:0] v1;
        @(negedge clk);
        reset     = rst;
        en        = e;
        up_down   = ud;
        load      = ld;
        load_val  = W'(lv);
        clr_flags = clr;
        model_step(0, rst, e, ud, ld, lv, clr, v0);
        model_step(1, rst, e, ud, ld, lv, clr, v1);
        exp_q0.push_back(v0);
        exp_q1.push_back(v1);
    endtask

    task automatic run(input int n, input bit e, input bit ud);
        for (int i = 0; i < n; i++) drive(1'b1, e, ud, 1'b0, 0, 1'b0);
    endtask

    // scoreboard monitor
    always @(posedge clk) begin
        logic [VW-1:0] got;
        logic [VW-1:0] exp;
        #1;
        cyc++;
        if (exp_q0.size() > 0) begin
            exp = exp_q0.pop_front();
            got = {count_w, tc_w, ovf_w, unf_w, at_max_w, at_min_w};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL dut_wrap cyc=%0d got{cnt,tc,ovf,unf,max,min}=%b exp=%b", cyc, got, exp);
            end
        end
        if (exp_q1.size() > 0) begin
            exp = exp_q1.pop_front();
            got = {count_s, tc_s, ovf_s, unf_s, at_max_s, at_min_s};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL dut_sat cyc=%0d got{cnt,tc,ovf,unf,max,min}=%b exp=%b", cyc, got, exp);
            end
        end
    end

    initial begin
        // reset held with load and enable asserted, then release and count
        drive(1'b0, 1'b1, 1'b1, 1'b1, 7, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 7, 1'b0);
        run(3, 1'b1, 1'b1);
        // up for 12 from 0: wrap 9->0, saturate holds at 9
        drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        run(12, 1'b1, 1'b1);
        // down from 0, then clear the flags
        drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        run(3, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        run(2, 1'b0, 1'b0);
        // en=0 holds while up_down toggles
        drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        // down to 0 and past it
        run(12, 1'b1, 1'b0);
        // clamped load, then in-range load, both with en=1
        drive(1'b1, 1'b1, 1'b1, 1'b1, 13, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 15, 1'b0);
        // clear coincident with a limit step: set wins
        drive(1'b1, 1'b0, 1'b1, 1'b1, 9, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        run(2, 1'b1, 1'b1);
        // reset mid-count discards the step
        drive(1'b1, 1'b0, 1'b1, 1'b1, 6, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        run(2, 1'b1, 1'b1);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(31) != 0,
                  $urandom_range(3) != 0,
                  1'($urandom_range(1)),
                  $urandom_range(7) == 0,
                  $urandom_range(15),
                  $urandom_range(15) == 0);
        end
        repeat (3) @(negedge clk);
        total++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d/%0d pending exp=0", exp_q0.size(), exp_q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_updown_counter_mod
